// File: rtl/uart_tx_fifo.sv
// Transmit byte queue in front of tx_engine: buffers processor writes and hands
// them out one at a time with a load pulse whenever the engine reports ready.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ovf_clr,
  input  logic             tx_txrdy,
  output logic             tx_load,
  output logic [WIDTH-1:0] tx_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             tx_done
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {StIdle, StLoad, StBusy} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             tx_done_q, tx_done_d;
  logic             seen_busy_q, seen_busy_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic wr_ok;
  logic pop;

  assign full  = (count_q == (AW + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign ovf   = ovf_q;
  assign tx_data = tx_data_q;
  assign tx_done = tx_done_q;

  // Full is judged on the registered count, so a same-edge pop never rescues a write.
  assign wr_ok = wr_en & ~full;
  assign pop   = (state_q == StIdle) & ~empty & tx_txrdy;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Datapath next-state: pointers, occupancy, overflow flag, output byte.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    tx_data_d = tx_data_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      tx_data_d = mem_q[rd_ptr_q];
    end

    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A rejected write takes priority over a clear on the same edge.
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // FSM next-state: issue a load, then wait for the engine to go busy and come back.
  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    tx_done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d     = StBusy;
        seen_busy_d = 1'b0;
      end
      StBusy: begin
        seen_busy_d = seen_busy_q | ~tx_txrdy;
        if (seen_busy_q && tx_txrdy) begin
          state_d   = StIdle;
          tx_done_d = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        seen_busy_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    tx_load = (state_q == StLoad);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      tx_data_q   <= '0;
      tx_done_q   <= 1'b0;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      tx_data_q   <= tx_data_d;
      tx_done_q   <= tx_done_d;
      seen_busy_q <= seen_busy_d;
    end
  end

endmodule
